// File: rtl/apb4_cpuif_bridge.sv
// ---------------------------------------------------------------------------
// apb4_cpuif_bridge
//
// Converts an APB4 slave port into the regblock's request/acknowledge CPU
// interface. At most one transaction is outstanding at a time. The regblock's
// stall signals are honoured, and read data and errors are returned on the
// APB response.
//
// Ports:
//   clk, arst_n           clock (rising edge), async active-low reset
//   s_apb_*               APB4 slave port (psel/penable/pwrite/paddr/pwdata/
//                         pstrb in; pready/prdata/pslverr out)
//   cpuif_req*            request, direction, word address, write data and
//                         per-bit write enable toward the regblock
//   cpuif_req_stall_*     regblock back-pressure, selected by direction
//   cpuif_rd_* / wr_*     regblock completion (ack, err, read data)
//
// FSM states:
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for an APB setup phase; fields are captured there
//   ST_REQ  | cpuif_req high; held while the direction's stall is high
//   ST_WAIT | request accepted; waiting for the matching ack
//   ST_DONE | pready high for one cycle with prdata/pslverr valid
// ---------------------------------------------------------------------------
module apb4_cpuif_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    arst_n,

    input  logic                    s_apb_psel,
    input  logic                    s_apb_penable,
    input  logic                    s_apb_pwrite,
    input  logic [ADDR_WIDTH-1:0]   s_apb_paddr,
    input  logic [DATA_WIDTH-1:0]   s_apb_pwdata,
    input  logic [DATA_WIDTH/8-1:0] s_apb_pstrb,
    output logic                    s_apb_pready,
    output logic [DATA_WIDTH-1:0]   s_apb_prdata,
    output logic                    s_apb_pslverr,

    output logic                    cpuif_req,
    output logic                    cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   cpuif_addr,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_biten,
    input  logic                    cpuif_req_stall_wr,
    input  logic                    cpuif_req_stall_rd,
    input  logic                    cpuif_rd_ack,
    input  logic                    cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]   cpuif_rd_data,
    input  logic                    cpuif_wr_ack,
    input  logic                    cpuif_wr_err
);

    localparam int STRB = DATA_WIDTH / 8;
    // Clears the byte-offset bits so the regblock always sees a word address.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic                  is_wr_q,   is_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] biten_q,   biten_d;
    logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
    logic                  pslverr_q, pslverr_d;
    logic                  pready_q,  pready_d;
    // Set when psel drops mid-transfer; the regblock access still finishes
    // but its response is thrown away.
    logic                  abort_q,   abort_d;

    logic                  stall_sel;
    logic                  ack_sel;
    logic                  err_sel;
    logic                  complete;
    logic [DATA_WIDTH-1:0] strb_bits;

    always_comb begin
        strb_bits = '0;
        for (int i = 0; i < STRB; i++) begin
            strb_bits[8*i +: 8] = {8{s_apb_pstrb[i]}};
        end
    end

    assign stall_sel = is_wr_q ? cpuif_req_stall_wr : cpuif_req_stall_rd;
    assign ack_sel   = is_wr_q ? cpuif_wr_ack       : cpuif_rd_ack;
    assign err_sel   = is_wr_q ? cpuif_wr_err       : cpuif_rd_err;

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        biten_d   = biten_q;
        abort_d   = abort_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        complete  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                // Only a setup phase launches; a lingering access phase
                // after completion must not re-issue the transfer.
                if (s_apb_psel && !s_apb_penable) begin
                    is_wr_d   = s_apb_pwrite;
                    addr_d    = s_apb_paddr & ADDR_MASK;
                    wr_data_d = s_apb_pwrite ? s_apb_pwdata : '0;
                    biten_d   = s_apb_pwrite ? strb_bits : '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!s_apb_psel) abort_d = 1'b1;
                if (!stall_sel) begin
                    if (ack_sel) complete = 1'b1;
                    else         state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!s_apb_psel) abort_d = 1'b1;
                if (ack_sel) complete = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (complete) begin
            if (abort_d) begin
                state_d = ST_IDLE;
            end else begin
                state_d   = ST_DONE;
                pready_d  = 1'b1;
                prdata_d  = is_wr_q ? '0 : cpuif_rd_data;
                pslverr_d = err_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            biten_q   <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            pready_q  <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            biten_q   <= biten_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            pready_q  <= pready_d;
            abort_q   <= abort_d;
        end
    end

    // Decoded from the state flop only, so no APB input reaches cpuif_req
    // combinationally.
    assign cpuif_req       = (state_q == ST_REQ);
    assign cpuif_req_is_wr = is_wr_q;
    assign cpuif_addr      = addr_q;
    assign cpuif_wr_data   = wr_data_q;
    assign cpuif_wr_biten  = biten_q;

    assign s_apb_pready    = pready_q;
    assign s_apb_prdata    = prdata_q;
    assign s_apb_pslverr   = pslverr_q;

endmodule

// File: tb/tb_apb4_cpuif_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb4_cpuif_bridge
//
// Directed bench for apb4_cpuif_bridge with a 32-bit data bus and a 16-bit
// address. The regblock side is played by the bench: it applies stalls and
// acks on a per-cycle script and drives wrong-direction stall/ack noise
// that the bridge must ignore.
// ---------------------------------------------------------------------------
module tb_apb4_cpuif_bridge;

    logic        clk;
    logic        arst_n;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        req, req_is_wr;
    logic [15:0] c_addr;
    logic [31:0] c_wdata, c_biten;
    logic        stall_wr, stall_rd;
    logic        rd_ack, rd_err, wr_ack, wr_err;
    logic [31:0] rd_data;

    int n_cmp  = 0;
    int n_fail = 0;

    apb4_cpuif_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk                (clk),
        .arst_n             (arst_n),
        .s_apb_psel         (psel),
        .s_apb_penable      (penable),
        .s_apb_pwrite       (pwrite),
        .s_apb_paddr        (paddr),
        .s_apb_pwdata       (pwdata),
        .s_apb_pstrb        (pstrb),
        .s_apb_pready       (pready),
        .s_apb_prdata       (prdata),
        .s_apb_pslverr      (pslverr),
        .cpuif_req          (req),
        .cpuif_req_is_wr    (req_is_wr),
        .cpuif_addr         (c_addr),
        .cpuif_wr_data      (c_wdata),
        .cpuif_wr_biten     (c_biten),
        .cpuif_req_stall_wr (stall_wr),
        .cpuif_req_stall_rd (stall_rd),
        .cpuif_rd_ack       (rd_ack),
        .cpuif_rd_err       (rd_err),
        .cpuif_rd_data      (rd_data),
        .cpuif_wr_ack       (wr_ack),
        .cpuif_wr_err       (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cpuif();
        stall_wr = 1'b0; stall_rd = 1'b0;
        rd_ack   = 1'b0; rd_err   = 1'b0; rd_data = 32'h0;
        wr_ack   = 1'b0; wr_err   = 1'b0;
    endtask

    function automatic logic [31:0] expand_strb(input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{s[i]}};
        return r;
    endfunction

    // One complete APB transfer. The setup phase is driven in the cycle after
    // entry; the task returns in the pready cycle with psel/penable still high.
    task automatic do_xfer(input logic wr, input logic [15:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb,
                           input logic [31:0] rd, input logic err,
                           input int nstall, input int nwait,
                           input logic [15:0] exp_addr,
                           input logic [31:0] exp_biten, input string tag);
        int  stalls, waits, reqs;
        bit  accepted, done, first_req;
        tick();
        n_cmp++;
        if (pready !== 1'b0 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_before_setup: pready=%b req=%b, required 0/0", tag, pready, req);
        end
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wd; pstrb = strb;
        clear_cpuif();
        stalls = 0; waits = 0; reqs = 0;
        accepted = 0; done = 0; first_req = 1;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            tick();
            penable = 1'b1;
            clear_cpuif();
            rd_data = ~rd;
            if (wr) stall_rd = 1'b1; else stall_wr = 1'b1;
            if (pready === 1'b1) begin
                done = 1;
                n_cmp++;
                if (cyc != nstall + nwait + 2) begin
                    n_fail++;
                    $display("FAIL %s latency: pready at cycle %0d, required %0d", tag, cyc, nstall + nwait + 2);
                end
                n_cmp++;
                if (reqs != nstall + 1) begin
                    n_fail++;
                    $display("FAIL %s req_cycles: %0d, required %0d", tag, reqs, nstall + 1);
                end
                n_cmp++;
                if (prdata !== (wr ? 32'h0 : rd)) begin
                    n_fail++;
                    $display("FAIL %s prdata: 0x%08h, required 0x%08h", tag, prdata, wr ? 32'h0 : rd);
                end
                n_cmp++;
                if (pslverr !== err) begin
                    n_fail++;
                    $display("FAIL %s pslverr: %b, required %b", tag, pslverr, err);
                end
            end else if (req === 1'b1) begin
                reqs++;
                if (first_req) begin
                    first_req = 0;
                    n_cmp++;
                    if (req_is_wr !== wr || c_addr !== exp_addr ||
                        c_wdata !== (wr ? wd : 32'h0) || c_biten !== exp_biten) begin
                        n_fail++;
                        $display("FAIL %s req_fields: is_wr=%b addr=0x%04h wdata=0x%08h biten=0x%08h, required %b 0x%04h 0x%08h 0x%08h",
                                 tag, req_is_wr, c_addr, c_wdata, c_biten, wr, exp_addr, wr ? wd : 32'h0, exp_biten);
                    end
                end
                if (stalls < nstall) begin
                    if (wr) stall_wr = 1'b1; else stall_rd = 1'b1;
                    stalls++;
                end else begin
                    accepted = 1;
                    if (nwait == 0) begin
                        if (wr) begin wr_ack = 1'b1; wr_err = err; end
                        else begin rd_ack = 1'b1; rd_err = err; rd_data = rd; end
                    end
                end
            end else if (accepted) begin
                waits++;
                // Wrong-direction completion with an error; must be ignored.
                if (wr) begin rd_ack = 1'b1; rd_err = 1'b1; end
                else begin wr_ack = 1'b1; wr_err = 1'b1; end
                if (waits == nwait) begin
                    if (wr) begin wr_ack = 1'b1; wr_err = err; end
                    else begin rd_ack = 1'b1; rd_err = err; rd_data = rd; end
                end
            end
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: no pready within 40 cycles, required completion", tag);
        end
        clear_cpuif();
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
        clear_cpuif();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({pready, prdata, pslverr, req, req_is_wr, c_addr, c_wdata, c_biten} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: pready=%b prdata=%h pslverr=%b req=%b is_wr=%b addr=%h wdata=%h biten=%h, required all 0",
                     pready, prdata, pslverr, req, req_is_wr, c_addr, c_wdata, c_biten);
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_write_basic();
        do_xfer(1'b1, 16'h0006, 32'hA5A5_1234, 4'b0101, 32'h0, 1'b0, 0, 0,
                16'h0004, 32'h00FF_00FF, "write_basic");
        // Hold the access phase into IDLE: it must not launch a new request.
        tick();
        tick();
        n_cmp++;
        if (req !== 1'b0 || pready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_reissue: req=%b pready=%b, required 0/0", req, pready);
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_read_stall();
        do_xfer(1'b0, 16'h0012, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 2, 1,
                16'h0010, 32'h0, "read_stall");
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_read_err();
        do_xfer(1'b0, 16'h0020, 32'h0, 4'h0, 32'h1234_5678, 1'b1, 0, 0,
                16'h0020, 32'h0, "read_err");
        tick();
        psel = 1'b0; penable = 1'b0;
        n_cmp++;
        if (pslverr !== 1'b0 || pready !== 1'b0 || prdata !== 32'h0) begin
            n_fail++;
            $display("FAIL read_err_after: pslverr=%b pready=%b prdata=0x%08h, required 0/0/0", pslverr, pready, prdata);
        end
    endtask

    task automatic test_spurious();
        psel = 1'b0; penable = 1'b0;
        wr_ack = 1'b1; wr_err = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (req !== 1'b0 || pready !== 1'b0 || pslverr !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: req=%b pready=%b pslverr=%b, required 0/0/0", req, pready, pslverr);
        end
        clear_cpuif();
        do_xfer(1'b0, 16'h0030, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0, 3,
                16'h0030, 32'h0, "spurious_read");
        // An ack arriving during DONE must be ignored too.
        wr_ack = 1'b1; rd_ack = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        clear_cpuif();
        tick();
        n_cmp++;
        if (req !== 1'b0 || pready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_ack_ignored: req=%b pready=%b, required 0/0", req, pready);
        end
    endtask

    task automatic test_abort();
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008;
        pwdata = 32'h1111_2222; pstrb = 4'hF;
        tick();
        stall_wr = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        tick();
        n_cmp++;
        if (req !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_req_held: req=%b, required 1", req);
        end
        stall_wr = 1'b0; wr_ack = 1'b1; wr_err = 1'b1;
        tick();
        clear_cpuif();
        n_cmp++;
        if (pready !== 1'b0 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_pready: pready=%b req=%b, required 0/0", pready, req);
        end
        tick();
        n_cmp++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: pready=%b pslverr=%b req=%b, required 0/0/0", pready, pslverr, req);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0046;
        tick();
        penable = 1'b1;
        n_cmp++;
        if (req !== 1'b1 || c_addr !== 16'h0044) begin
            n_fail++;
            $display("FAIL rstmid_req: req=%b addr=0x%04h, required 1 0x0044", req, c_addr);
        end
        tick();
        n_cmp++;
        if (req !== 1'b0 || pready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_wait: req=%b pready=%b, required 0/0", req, pready);
        end
        arst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pready, prdata, pslverr, req, req_is_wr, c_addr, c_wdata, c_biten} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: pready=%b req=%b addr=%h prdata=%h, required all 0", pready, req, c_addr, prdata);
        end
        #2;
        arst_n = 1'b1;
        psel = 1'b0; penable = 1'b0;
        tick();
        rd_ack = 1'b1; rd_data = 32'h5555_AAAA;
        tick();
        clear_cpuif();
        n_cmp++;
        if (pready !== 1'b0 || req !== 1'b0 || prdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_late_ack: pready=%b req=%b prdata=0x%08h, required 0/0/0", pready, req, prdata);
        end
        do_xfer(1'b1, 16'h00A3, 32'h0BAD_F00D, 4'b1000, 32'h0, 1'b0, 1, 0,
                16'h00A0, 32'hFF00_0000, "rstmid_write");
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        for (int k = 0; k < 10; k++) begin
            a = 16'($urandom_range(0, 16'hFFFF));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (k % 2 == 0)
                do_xfer(1'b0, a, 32'h0, 4'h0, d, 1'b0,
                        $urandom_range(0, 3), $urandom_range(0, 3),
                        a & 16'hFFFC, 32'h0, $sformatf("b2b_rd%0d", k));
            else
                do_xfer(1'b1, a, d, s, 32'h0, 1'b0,
                        $urandom_range(0, 3), $urandom_range(0, 3),
                        a & 16'hFFFC, expand_strb(s), $sformatf("b2b_wr%0d", k));
        end
        tick();
        psel = 1'b0; penable = 1'b0;
        tick();
        n_cmp++;
        if (req !== 1'b0 || pready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end_idle: req=%b pready=%b, required 0/0", req, pready);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_stall();
        test_read_err();
        test_spurious();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
